fir_mac_filter: RTL and testbench

Ten-tap FIR equalizer datapath for the audio path. It takes 24-bit samples into a sliding signal window and holds a writable bank of 16-bit tap coefficients. One multiply-accumulate runs per cycle to produce a 33-bit filtered result, a 16-bit scaled output and a one-cycle done strobe per sample. It sits between the sample capture logic and the output/DAC stage.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac.sv | 40 ++++
 rtl/fir_mac_filter.sv | 144 ++++++++++++++
 tb/tb_fir_mac_filter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_pkg : shared widths, FSM state type and output saturation for the FIR.
// Rev 1.0
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int NUM_TAPS_DEF = 10;
  localparam int SAMPLE_W     = 16;
  localparam int COEF_W       = 16;
  localparam int PROD_W       = 32;
  localparam int ACC_W        = 33;
  localparam int OUT_W        = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } fir_state_e;

  function automatic logic signed [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 33'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_mac : registered wrapping accumulator with clear, enable and product in.
// Rev 1.0
// ---------------------------------------------------------------------------
module fir_mac
  import fir_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic signed [ACC_W-1:0]  o_sum
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod_ext;

  assign w_prod_ext = ACC_W'(i_prod);
  // o_sum is the running total including the current product, so the owner
  // can capture the final tap without waiting an extra cycle.
  assign o_sum      = r_acc + w_prod_ext;
  assign o_acc      = r_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_acc <= '0;
      end else begin
        r_acc <= o_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_mac_filter : N-tap FIR, one multiply-accumulate per enabled cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = NUM_TAPS_DEF,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clk_en_i,
  input  logic                    signal_en_i,
  input  logic [23:0]             signal_i,
  input  logic                    coef_we_i,
  input  logic [7:0]              tapnum_i,
  input  logic [15:0]             tap_i,
  output logic signed [ACC_W-1:0] result_o,
  output logic signed [OUT_W-1:0] final_o,
  output logic                    done_o
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;

  sample_t                 r_window     [NUM_TAPS];
  sample_t                 w_window_nxt [NUM_TAPS];
  sample_t                 r_frame      [NUM_TAPS];
  coef_t                   r_coef       [NUM_TAPS];
  fir_state_e              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pending;
  logic                    w_last;
  logic                    w_start;
  logic                    w_acc_en;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [ACC_W-1:0]  w_acc_unused;
  logic                     w_sig_unused;

  assign w_sig_unused = ^signal_i[23:SAMPLE_W];

  always_comb begin
    w_window_nxt = r_window;
    if (signal_en_i) begin
      w_window_nxt[0] = $signed(signal_i[SAMPLE_W-1:0]);
      for (int k = 1; k < NUM_TAPS; k++) begin
        w_window_nxt[k] = r_window[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_window[k] <= '0;
      end
    end else if (clk_en_i) begin
      r_window <= w_window_nxt;
    end
  end

  // Coefficients are read live by the MAC, so a write mid-pass affects later taps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_coef[k] <= '0;
      end
    end else if (clk_en_i && coef_we_i && (32'(tapnum_i) < NUM_TAPS)) begin
      r_coef[tapnum_i[IDX_W-1:0]] <= $signed(tap_i);
    end
  end

  assign w_last    = (r_state == ST_MAC) && (r_idx == LAST_IDX);
  assign w_start   = ((r_state == ST_IDLE) && signal_en_i) ||
                     (w_last && (r_pending || signal_en_i));
  assign w_acc_en  = clk_en_i && (w_start || (r_state == ST_MAC));
  assign w_prod    = PROD_W'(r_coef[r_idx]) * PROD_W'(r_frame[r_idx]);
  assign w_shifted = w_sum >>> OUT_SHIFT;

  fir_mac u_mac (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_en   (w_acc_en),
    .i_clr  (w_start),
    .i_prod (w_prod),
    .o_acc  (w_acc_unused),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      result_o  <= '0;
      final_o   <= '0;
      done_o    <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_frame[k] <= '0;
      end
    end else if (clk_en_i) begin
      done_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (signal_en_i) begin
            r_frame <= w_window_nxt;
            r_idx   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (w_last) begin
            result_o  <= w_sum;
            final_o   <= sat16(w_shifted);
            done_o    <= 1'b1;
            r_pending <= 1'b0;
            // Any samples seen during the pass collapse into one pass over the newest window.
            if (r_pending || signal_en_i) begin
              r_frame <= w_window_nxt;
              r_idx   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
            if (signal_en_i) begin
              r_pending <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fir_mac_filter : directed vectors against a pass-level model of the FIR.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_mac_filter;

  localparam int NT = 10;
  localparam int SH = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  logic        sen   = 1'b0;
  logic [23:0] sig   = '0;
  logic        we    = 1'b0;
  logic [7:0]  tn    = '0;
  logic [15:0] tp    = '0;
  logic [32:0] result;
  logic [15:0] fin;
  logic        done;

  int errors = 0;
  int checks = 0;

  fir_mac_filter #(.NUM_TAPS(NT), .OUT_SHIFT(SH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clk_en_i    (en),
    .signal_en_i (sen),
    .signal_i    (sig),
    .coef_we_i   (we),
    .tapnum_i    (tn),
    .tap_i       (tp),
    .result_o    (result),
    .final_o     (fin),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pass-level model: window, coefficient bank, and a pass that finishes
  // NT enabled edges after it starts, summing coef*snapshot with 33-bit wrap.
  longint      m_win  [NT];
  longint      m_coef [NT];
  int          m_cnt;
  bit          m_pend;
  logic [32:0] m_sum;
  logic [32:0] e_res;
  logic [15:0] e_fin;
  logic        e_done;

  function automatic logic [15:0] msat(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [32:0] dot();
    longint s;
    s = 0;
    for (int i = 0; i < NT; i++) s += m_coef[i] * m_win[i];
    return s[32:0];
  endfunction

  always @(posedge clk) begin
    bit          l_en, l_sen, l_we;
    logic [15:0] l_smp, l_tp;
    logic [7:0]  l_tn;
    l_en = en; l_sen = sen; l_we = we; l_smp = sig[15:0]; l_tp = tp; l_tn = tn;
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) begin m_win[i] = 0; m_coef[i] = 0; end
      m_cnt = 0; m_pend = 0; m_sum = '0;
      e_res = '0; e_fin = '0; e_done = 1'b0;
    end else if (l_en) begin
      e_done = 1'b0;
      if (l_we && l_tn < NT) m_coef[l_tn] = longint'($signed(l_tp));
      if (l_sen) begin
        for (int i = NT - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = longint'($signed(l_smp));
        m_pend = 1;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_res  = m_sum;
          e_fin  = msat(longint'($signed(m_sum)) >>> SH);
          e_done = 1'b1;
        end
      end
      if (m_cnt == 0 && m_pend) begin
        m_sum  = dot();
        m_cnt  = NT;
        m_pend = 0;
      end
    end
    #1;
    chk("done_o", {32'b0, done}, {32'b0, e_done});
    chk("result_o", result, e_res);
    chk("final_o", {17'b0, fin}, {17'b0, e_fin});
  end

  task automatic cyc(input bit e, input bit s, input logic [15:0] smp,
                     input bit w, input logic [7:0] n, input logic [15:0] t);
    en = e; sen = s; sig = {8'hA5, smp}; we = w; tn = n; tp = t;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 16'h0);
  endtask

  task automatic wcoef(input int n, input logic [15:0] v);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 8'(n), v);
  endtask

  task automatic sample(input logic [15:0] v);
    cyc(1'b1, 1'b1, v, 1'b0, 8'h0, 16'h0);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      idle(1);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: no done_o within %0d cycles", budget);
    end
  endtask

  initial begin
    int lat, w, nd, last, gaps_bad;
    repeat (3) @(negedge clk);
    chk("reset_result", result, 33'h0);
    chk("reset_final", {17'b0, fin}, 33'h0);
    chk("reset_done", {32'b0, done}, 33'h0);
    rst_n = 1'b1;

    // Basic MAC, including ignored writes at tapnum = NT and beyond.
    wcoef(0, 16'd4); wcoef(1, 16'd1); wcoef(2, 16'd2); wcoef(3, 16'd1);
    wcoef(10, 16'h7777); wcoef(200, 16'h1234);
    sample(16'd4); sample(16'd3); sample(16'd2);
    idle(30);
    sample(16'd5);
    wait_done(20, lat);
    chk("basic_latency", 33'(lat), 33'd10);
    chk("basic_result", result, 33'd32);
    chk("basic_final", {17'b0, fin}, 33'd32);

    // Signed product, coefficient write on the same edge as the sample.
    wcoef(1, 16'h0); wcoef(2, 16'h0); wcoef(3, 16'h0);
    cyc(1'b1, 1'b1, 16'd2, 1'b1, 8'd0, 16'hFFFF);
    wait_done(20, lat);
    chk("signed_result", result, 33'h1_FFFF_FFFE);
    chk("signed_final", {17'b0, fin}, {17'b0, 16'hFFFE});

    // Positive saturation.
    wcoef(0, 16'h7FFF);
    sample(16'h7FFF);
    wait_done(20, lat);
    chk("sat_result", result, 33'h0_3FFF_0001);
    chk("sat_final", {17'b0, fin}, {17'b0, 16'h7FFF});

    // Enable stall mid-pass, then outputs hold while disabled after done.
    for (int i = 0; i < NT; i++) wcoef(i, 16'(i * 37 - 100));
    sample(16'd1234);
    idle(3);
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 16'h0);
    wait_done(20, w);
    chk("stall_latency", 33'(6 + w), 33'd13);
    repeat (2) cyc(1'b0, 1'b1, 16'h5555, 1'b1, 8'd0, 16'h1111);
    chk("stall_done_hold", {32'b0, done}, 33'h1);
    idle(5);

    // Streaming: a sample every cycle for 30 cycles.
    nd = 0; last = -1; gaps_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 30) sample(16'($urandom));
      else idle(1);
      if (done === 1'b1) begin
        if (last >= 0 && i - last != 10) gaps_bad++;
        last = i;
        nd++;
      end
    end
    chk("stream_passes", 33'(nd), 33'd4);
    chk("stream_gaps", 33'(gaps_bad), 33'd0);

    // Asynchronous reset in the middle of a pass.
    sample(16'd777);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 33'h0);
    chk("async_rst_final", {17'b0, fin}, 33'h0);
    chk("async_rst_done", {32'b0, done}, 33'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    chk("no_done_after_rst", {32'b0, done}, 33'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
